pipo: RTL and testbench

- Parallel-in, parallel-out width-converting register.
- An 8-bit word is captured in one clock when load is high.
- While load is low, the stored word is presented on a 4-bit output one slice per clock, most-significant slice first, wrapping cyclically.
- Used as a narrow-bus serializer between a byte-wide producer and a nibble-wide consumer.

---
 rtl/pipo_pkg.sv | 11 +
 rtl/pipo_slice_mux.sv | 39 +++
 rtl/pipo.sv | 58 +++++
 tb/tb_pipo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipo_pkg.sv
// Shared helpers for the pipo width-converting register.
// Sizes the slice index so that a single-slice configuration still has a 1-bit counter.
package pipo_pkg;

   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pipo_slice_mux.sv
// Purely combinational selector that picks one DOUT_W-wide slice of a DIN_W-wide word.
// Slice 0 is the most-significant slice when MSB_FIRST is set, otherwise the least-significant one.
module pipo_slice_mux
   import pipo_pkg::*;
#(
   parameter int DIN_W     = 8,
   parameter int DOUT_W    = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter int NSLICE    = DIN_W / DOUT_W,
   parameter int IDX_W     = clog2_min1(NSLICE)
) (
   input  logic [DIN_W-1:0]  data,
   input  logic [IDX_W-1:0]  idx,
   output logic [DOUT_W-1:0] slice
);

   generate
      if (MSB_FIRST) begin : g_msb_first
         always_comb begin
            slice = '0;
            for (int k = 0; k < NSLICE; k++) begin
               if (idx == IDX_W'(k)) begin
                  slice = data[DIN_W-1-k*DOUT_W -: DOUT_W];
               end
            end
         end
      end else begin : g_lsb_first
         always_comb begin
            slice = '0;
            for (int k = 0; k < NSLICE; k++) begin
               if (idx == IDX_W'(k)) begin
                  slice = data[k*DOUT_W +: DOUT_W];
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/pipo.sv
// Parallel-in, parallel-out width converter: captures a DIN_W word on load and
// presents it DOUT_W bits per clock, cycling through the slices while load is low.
module pipo
   import pipo_pkg::*;
#(
   parameter int DIN_W     = 8,
   parameter int DOUT_W    = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DIN_W-1:0]  d_in,
   output logic [DOUT_W-1:0] q,
   output logic              last
);

   localparam int NSLICE = DIN_W / DOUT_W;
   localparam int IDX_W  = clog2_min1(NSLICE);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

   generate
      if ((DIN_W % DOUT_W) != 0 || DOUT_W < 1) begin : g_bad_width
         $error("pipo: DIN_W must be a positive integer multiple of DOUT_W");
      end
   endgenerate

   logic [DIN_W-1:0] data_r;
   logic [IDX_W-1:0] idx;

   // Load always wins and restarts at slice 0; otherwise step through slices with wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= '0;
         idx    <= '0;
      end else if (load) begin
         data_r <= d_in;
         idx    <= '0;
      end else begin
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   pipo_slice_mux #(
      .DIN_W     (DIN_W),
      .DOUT_W    (DOUT_W),
      .MSB_FIRST (MSB_FIRST),
      .NSLICE    (NSLICE),
      .IDX_W     (IDX_W)
   ) u_slice_mux (
      .data  (data_r),
      .idx   (idx),
      .slice (q)
   );

   assign last = (idx == IDX_LAST);

endmodule

// File: tb/tb_pipo.sv
// Directed, table-driven bench for pipo, covering MSB/LSB-first, 2-bit and single-slice builds.
module tb_pipo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic [7:0] d_in;

   logic [3:0] q_msb, q_lsb;
   logic       last_msb, last_lsb;
   logic [1:0] q_n2;
   logic       last_n2;
   logic [7:0] q_w;
   logic       last_w;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipo #(.DIN_W(8), .DOUT_W(4), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .load(load), .d_in(d_in), .q(q_msb), .last(last_msb)
   );
   pipo #(.DIN_W(8), .DOUT_W(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .load(load), .d_in(d_in), .q(q_lsb), .last(last_lsb)
   );
   pipo #(.DIN_W(8), .DOUT_W(2), .MSB_FIRST(1'b1)) dut_n2 (
      .clk(clk), .rst_n(rst_n), .load(load), .d_in(d_in), .q(q_n2), .last(last_n2)
   );
   pipo #(.DIN_W(8), .DOUT_W(8), .MSB_FIRST(1'b1)) dut_w (
      .clk(clk), .rst_n(rst_n), .load(load), .d_in(d_in), .q(q_w), .last(last_w)
   );

   typedef struct {
      logic       ld;
      logic [7:0] d;
      logic [3:0] q;
      logic       last;
   } vec_t;

   vec_t vecs[16];

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive away from the active edge, then sample just after it.
   task automatic applyStimulus(input logic ld, input logic [7:0] d);
      @(negedge clk);
      load = ld;
      d_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0] exp_n2[5];
      logic       exp_last_n2[5];
      logic [3:0] exp_iso[3];

      // Expected values for the default 8-to-4 MSB-first build, computed by hand.
      vecs[0]  = '{1'b1, 8'hD0, 4'hD, 1'b0};
      vecs[1]  = '{1'b1, 8'hD0, 4'hD, 1'b0};
      vecs[2]  = '{1'b0, 8'hFF, 4'h0, 1'b1};
      vecs[3]  = '{1'b0, 8'h11, 4'hD, 1'b0};
      vecs[4]  = '{1'b0, 8'h22, 4'h0, 1'b1};
      vecs[5]  = '{1'b0, 8'h33, 4'hD, 1'b0};
      vecs[6]  = '{1'b0, 8'h44, 4'h0, 1'b1};
      vecs[7]  = '{1'b0, 8'h55, 4'hD, 1'b0};
      vecs[8]  = '{1'b0, 8'h66, 4'h0, 1'b1};
      vecs[9]  = '{1'b1, 8'h3C, 4'h3, 1'b0};
      vecs[10] = '{1'b0, 8'hAA, 4'hC, 1'b1};
      vecs[11] = '{1'b1, 8'h12, 4'h1, 1'b0};
      vecs[12] = '{1'b1, 8'h34, 4'h3, 1'b0};
      vecs[13] = '{1'b1, 8'h56, 4'h5, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 4'h6, 1'b1};
      vecs[15] = '{1'b0, 8'hEE, 4'h5, 1'b0};

      rst_n = 1'b0;
      load  = 1'b0;
      d_in  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset q_msb", q_msb, 4'h0);
      checkOutput("reset last_msb", last_msb, 1'b0);
      checkOutput("reset q_n2", q_n2, 2'b00);
      checkOutput("reset last_n2", last_n2, 1'b0);
      checkOutput("reset q_w", q_w, 8'h00);
      checkOutput("reset last_w", last_w, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset must clear a loaded word without a clock edge.
      applyStimulus(1'b1, 8'hA5);
      checkOutput("preload q_msb", q_msb, 4'hA);
      checkOutput("preload q_w", q_w, 8'hA5);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset q_msb", q_msb, 4'h0);
      checkOutput("async reset last_msb", last_msb, 1'b0);
      checkOutput("async reset q_w", q_w, 8'h00);
      checkOutput("async reset last_w", last_w, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].ld, vecs[i].d);
         checkOutput($sformatf("vec%0d q", i), q_msb, vecs[i].q);
         checkOutput($sformatf("vec%0d last", i), last_msb, vecs[i].last);
      end
      checkOutput("single-slice q after continuous load", q_w, 8'h56);
      checkOutput("single-slice last", last_w, 1'b1);

      // d_in wiggling between edges while load is low must not reach q.
      applyStimulus(1'b1, 8'h9E);
      checkOutput("iso load q", q_msb, 4'h9);
      exp_iso = '{4'hE, 4'h9, 4'hE};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         load = 1'b0;
         d_in = 8'hFF;
         #1;
         checkOutput($sformatf("iso mid%0d q", i), q_msb, (i % 2 == 0) ? 4'h9 : 4'hE);
         d_in = 8'h00;
         #2;
         d_in = 8'h77;
         @(posedge clk);
         #1;
         checkOutput($sformatf("iso%0d q", i), q_msb, exp_iso[i]);
      end

      // LSB-first build sees the low nibble first.
      applyStimulus(1'b1, 8'hD0);
      checkOutput("lsb load q", q_lsb, 4'h0);
      checkOutput("lsb load last", last_lsb, 1'b0);
      applyStimulus(1'b0, 8'h5A);
      checkOutput("lsb step1 q", q_lsb, 4'hD);
      checkOutput("lsb step1 last", last_lsb, 1'b1);
      applyStimulus(1'b0, 8'hA5);
      checkOutput("lsb step2 q", q_lsb, 4'h0);
      checkOutput("lsb step2 last", last_lsb, 1'b0);

      // Four-slice build: 8'hB4 = 10 11 01 00, last on the fourth slice, then wrap.
      exp_n2      = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
      exp_last_n2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      applyStimulus(1'b1, 8'hB4);
      checkOutput("n2 slice0 q", q_n2, exp_n2[0]);
      checkOutput("n2 slice0 last", last_n2, exp_last_n2[0]);
      checkOutput("w load q", q_w, 8'hB4);
      for (int i = 1; i < 5; i++) begin
         applyStimulus(1'b0, 8'h0F);
         checkOutput($sformatf("n2 slice%0d q", i), q_n2, exp_n2[i]);
         checkOutput($sformatf("n2 slice%0d last", i), last_n2, exp_last_n2[i]);
      end
      checkOutput("w hold q", q_w, 8'hB4);
      checkOutput("w hold last", last_w, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
